// File: rtl/serial_add_ctrl_if.sv
// Start/operand request and busy/done/result response bundle
// for the bit-serial adder/subtractor.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder cell reused
// over WIDTH cycles, LSB first, with IDLE/RUN/DONE control.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic x, y, s, co;

  always_comb begin
    x  = a_q[cnt_q];
    y  = b_q[cnt_q];
    s  = x ^ y ^ c_q;
    co = (x & y) | (c_q & (x ^ y));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          // subtract folds into add: A + ~B + 1
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub | bus.cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d = {s, res_q[WIDTH-1:1]};
        c_d   = co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {co, s, res_q[WIDTH-1:1]};
          ovf_d   = c_q ^ co;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results queued
// at start, compared when done pulses.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W+1:0] sb_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic ci, input logic sb);
    logic [W-1:0] y;
    logic [W:0]   s;
    logic         c, ov;
    y  = sb ? ~b : b;
    c  = sb ? 1'b1 : ci;
    s  = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, c};
    ov = (a[W-1] == y[W-1]) && (s[W-1] != a[W-1]);
    return {ov, s};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl",
          32'(bus.busy & bus.done), 32'd0);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [W+1:0] e;
          e = sb_q.pop_front();
          chk("sum", 32'(bus.sum), 32'(e[W:0]));
          chk("ovf", 32'(bus.ovf), 32'(e[W+1]));
        end
      end
    end
  end

  // returns on the negedge right after the accepting edge
  task automatic start_op(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic ci, input logic sb);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.sub   = sb;
    bus.start = 1'b1;
    sb_q.push_back(model(a, b, ci, sb));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bsy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic ci, input logic sb);
    int lat, bsy;
    start_op(a, b, ci, sb);
    wait_done(lat, bsy);
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(bsy), 32'(W));
  endtask

  initial begin
    int lat, bsy;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h0F, 8'h01, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 1'b1);
    run_op(8'h80, 8'h01, 1'b0, 1'b1);

    // start during RUN is ignored
    start_op(8'h02, 8'h03, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    bus.a     = 8'h11;
    bus.b     = 8'h11;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bsy);
    chk("ign_done_seen", 32'(bus.done), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("ign_single_done", 32'(bus.done), 32'd0);
    end

    // result holds through the next RUN
    start_op(8'h40, 8'h01, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      if (bus.done) break;
      chk("hold_sum", 32'(bus.sum), 32'h005);
      @(negedge clk);
    end
    chk("hold_done_seen", 32'(bus.done), 32'd1);

    // back-to-back with start held through DONE
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    sb_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    @(negedge clk);
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_no_idle", 32'(bus.busy), 32'd1);
    wait_done(lat, bsy);
    chk("b2b_latency", 32'(lat), 32'(W));

    // reset in the 4th RUN cycle aborts
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    repeat (12) @(negedge clk);
    run_op(8'h01, 8'h01, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom),
             1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
